// File: rtl/axilite_test_pkg.sv
// Shared constants and FSM encodings for the AXI-Lite test responder.
// Response codes follow the AXI definitions; states are one-hot-free binary.
package axilite_test_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_COLLECT = 1'b0,
        W_RESP    = 1'b1
    } wstate_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_WAIT = 2'b01,
        R_DATA = 2'b10
    } rstate_e;

    function automatic logic [1:0] resp_for(input logic in_range);
        return in_range ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage

// File: rtl/axilite_test_ram.sv
// Word memory for the test responder: synchronous write, read data latched on read enable.
// A read issued together with a write to the same word returns the pre-write contents.
module axilite_test_ram #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 256,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic              rzero_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Out-of-range reads return zero rather than an aliased entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= rzero_i ? '0 : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axilite_slave_test_mem.sv
// AXI-Lite slave memory model closing the loop for the chipset AXI-Lite test master.
// Independent write (AW/W collect, B) and read (latency-delayed R) channels share one RAM.
module axilite_slave_test_mem
    import axilite_test_pkg::*;
#(
    parameter int          AXILITE_ADDR_WIDTH = 64,
    parameter int          AXILITE_DATA_WIDTH = 64,
    parameter logic [63:0] ADDR_BASE          = 64'h8000_0000,
    parameter int          MEM_DEPTH          = 256,
    parameter int          READ_LATENCY       = 2,
    parameter int          STALL_PERIOD       = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [AXILITE_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [AXILITE_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [AXILITE_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [AXILITE_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready
);

    localparam int AW    = AXILITE_ADDR_WIDTH;
    localparam int DW    = AXILITE_DATA_WIDTH;
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int LAT_W = $clog2(READ_LATENCY + 1);

    localparam logic [AW-1:0]    BASE     = AW'(ADDR_BASE);
    localparam logic [AW-1:0]    DEPTH_A  = AW'(MEM_DEPTH);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY - 1);

    logic stall;

    generate
        if (STALL_PERIOD > 0) begin : g_stall
            localparam int SC_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
            localparam logic [SC_W-1:0] LAST = SC_W'(STALL_PERIOD - 1);
            logic [SC_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = (cnt_q == LAST) ? '0 : cnt_q + SC_W'(1);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign stall = (cnt_q == LAST);
        end else begin : g_no_stall
            assign stall = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wstate_e         wstate_q, wstate_d;
    logic            aw_held_q, aw_held_d;
    logic            w_held_q, w_held_d;
    logic [AW-1:0]   awaddr_q;
    logic [DW-1:0]   wdata_q;
    logic [1:0]      bresp_q, bresp_d;
    logic            aw_rdy, w_rdy, b_vld;
    logic            commit;
    logic [AW-1:0]   wr_addr, wr_idx;
    logic [DW-1:0]   wr_data;
    logic            wr_in_range;

    // A beat arriving this cycle bypasses its hold register so commit needs no extra cycle.
    assign wr_addr     = aw_held_q ? awaddr_q : s_axi_awaddr;
    assign wr_data     = w_held_q ? wdata_q : s_axi_wdata;
    assign wr_idx      = wr_addr - BASE;
    assign wr_in_range = (wr_idx < DEPTH_A);

    always_comb begin
        wstate_d  = wstate_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        bresp_d   = bresp_q;
        aw_rdy    = 1'b0;
        w_rdy     = 1'b0;
        b_vld     = 1'b0;
        commit    = 1'b0;
        case (wstate_q)
            W_COLLECT: begin
                aw_rdy = !aw_held_q && !stall && !rst;
                w_rdy  = !w_held_q && !stall && !rst;
                if (s_axi_awvalid && aw_rdy) aw_held_d = 1'b1;
                if (s_axi_wvalid && w_rdy)   w_held_d  = 1'b1;
                if (aw_held_d && w_held_d) begin
                    commit    = 1'b1;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    bresp_d   = resp_for(wr_in_range);
                    wstate_d  = W_RESP;
                end
            end
            W_RESP: begin
                b_vld = 1'b1;
                if (s_axi_bready) wstate_d = W_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q  <= W_COLLECT;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            wstate_q  <= wstate_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            bresp_q   <= bresp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (s_axi_awvalid && aw_rdy) awaddr_q <= s_axi_awaddr;
        if (s_axi_wvalid && w_rdy)   wdata_q  <= s_axi_wdata;
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rstate_e          rstate_q, rstate_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [1:0]       rresp_q, rresp_d;
    logic             ar_rdy, ar_fire, r_vld;
    logic [AW-1:0]    rd_idx;
    logic             rd_in_range;

    assign rd_idx      = s_axi_araddr - BASE;
    assign rd_in_range = (rd_idx < DEPTH_A);
    assign ar_rdy      = (rstate_q == R_IDLE) && !stall && !rst;
    assign ar_fire     = s_axi_arvalid && ar_rdy;

    always_comb begin
        rstate_d = rstate_q;
        lat_d    = lat_q;
        rresp_d  = rresp_q;
        r_vld    = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                if (ar_fire) begin
                    rresp_d = resp_for(rd_in_range);
                    if (READ_LATENCY <= 1) begin
                        rstate_d = R_DATA;
                    end else begin
                        rstate_d = R_WAIT;
                        lat_d    = LAT_LOAD;
                    end
                end
            end
            R_WAIT: begin
                lat_d = lat_q - LAT_W'(1);
                if (lat_q <= LAT_W'(1)) rstate_d = R_DATA;
            end
            R_DATA: begin
                r_vld = 1'b1;
                if (s_axi_rready) rstate_d = R_IDLE;
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q <= R_IDLE;
            lat_q    <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rstate_q <= rstate_d;
            lat_q    <= lat_d;
            rresp_q  <= rresp_d;
        end
    end

    axilite_test_ram #(
        .DATA_W (DW),
        .DEPTH  (MEM_DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (commit && wr_in_range),
        .waddr_i (wr_idx[IDX_W-1:0]),
        .wdata_i (wr_data),
        .re_i    (ar_fire),
        .rzero_i (!rd_in_range),
        .raddr_i (rd_idx[IDX_W-1:0]),
        .rdata_o (s_axi_rdata)
    );

    assign s_axi_awready = aw_rdy;
    assign s_axi_wready  = w_rdy;
    assign s_axi_bvalid  = b_vld;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = ar_rdy;
    assign s_axi_rvalid  = r_vld;
    assign s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axilite_slave_test_mem.sv
// Randomized self-checking bench for axilite_slave_test_mem against an array-based memory model.
// The DUT runs with STALL_PERIOD=4 so periodic backpressure is exercised by every scenario.
module tb_axilite_slave_test_mem;

    localparam int          AW    = 64;
    localparam int          DW    = 64;
    localparam int          DEPTH = 256;
    localparam int          RL    = 2;
    localparam int          SP    = 4;
    localparam logic [63:0] BASE  = 64'h8000_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] awaddr = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [DW-1:0] wdata = '0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b0;
    logic [AW-1:0] araddr = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int since_rst = 0;

    logic [63:0] ref_mem [DEPTH];

    axilite_slave_test_mem #(
        .AXILITE_ADDR_WIDTH (AW),
        .AXILITE_DATA_WIDTH (DW),
        .ADDR_BASE          (BASE),
        .MEM_DEPTH          (DEPTH),
        .READ_LATENCY       (RL),
        .STALL_PERIOD       (SP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready)
    );

    always #5 clk = ~clk;

    // Cycles elapsed since reset released; the stall slot is every SP-th of them.
    always @(posedge clk) since_rst <= rst ? 0 : since_rst + 1;

    function automatic bit exp_stall();
        return (since_rst % SP) == (SP - 1);
    endfunction

    function automatic bit in_range(input logic [63:0] a);
        return (a >= BASE) && (a < BASE + 64'(DEPTH));
    endfunction

    function automatic int idx_of(input logic [63:0] a);
        return int'(a - BASE);
    endfunction

    function automatic logic [63:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return BASE + 64'(DEPTH) + 64'($urandom_range(0, 1000));
        if (sel == 1) return BASE - 64'($urandom_range(1, 1000));
        return BASE + 64'($urandom_range(0, DEPTH - 1));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [63:0] addr, input logic [63:0] data, input int w_lead,
                             input int b_delay, output logic [1:0] resp, output int lat,
                             output bit reopen, output bit b_stable, output bit b_after, output bit ok);
        int cyc, aw_t, w_t;
        bit aw_done, w_done;
        aw_t = (w_lead > 0) ? w_lead : 0;
        w_t  = (w_lead < 0) ? -w_lead : 0;
        aw_done = 0; w_done = 0; reopen = 0; b_stable = 1; b_after = 0; ok = 0;
        resp = 2'bxx; lat = -1; cyc = 0;
        awaddr = addr; wdata = data; bready = 0;
        while (!(aw_done && w_done) && cyc < 200) begin
            awvalid = !aw_done && (cyc >= aw_t);
            wvalid  = !w_done && (cyc >= w_t);
            if (aw_done && awready) reopen = 1;
            if (w_done && wready) reopen = 1;
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) w_done = 1;
            tick();
            cyc++;
        end
        awvalid = 0; wvalid = 0;
        if (!(aw_done && w_done)) return;
        lat = 0;
        while (!bvalid && lat < 50) begin
            tick();
            lat++;
        end
        if (!bvalid) return;
        resp = bresp;
        for (int i = 0; i < b_delay; i++) begin
            tick();
            if (!bvalid || bresp !== resp || awready || wready) b_stable = 0;
        end
        bready = 1;
        tick();
        b_after = bvalid;
        bready = 0;
        ok = 1;
    endtask

    task automatic axi_read(input logic [63:0] addr, input int r_delay, output logic [63:0] data,
                            output logic [1:0] resp, output int lat, output bit r_stable,
                            output bit r_after, output bit ok);
        int cyc;
        cyc = 0; ok = 0; r_stable = 1; r_after = 0; lat = -1; data = 'x; resp = 2'bxx;
        araddr = addr; arvalid = 1; rready = 0;
        while (!arready && cyc < 50) begin
            tick();
            cyc++;
        end
        if (!arready) begin
            arvalid = 0;
            return;
        end
        tick();
        arvalid = 0;
        lat = 1;
        while (!rvalid && lat < 50) begin
            tick();
            lat++;
        end
        if (!rvalid) return;
        data = rdata; resp = rresp;
        for (int i = 0; i < r_delay; i++) begin
            tick();
            if (!rvalid || rdata !== data || rresp !== resp || arready) r_stable = 0;
        end
        rready = 1;
        tick();
        r_after = rvalid;
        rready = 0;
        ok = 1;
    endtask

    task automatic test_reset();
        rst = 1; awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
        awaddr = BASE; araddr = BASE; wdata = 64'h1234;
        repeat (3) tick();
        vectors++; if (awready !== 1'b0) begin miscompares++; $display("FAIL reset_awready: got %b want 0", awready); end
        vectors++; if (wready !== 1'b0) begin miscompares++; $display("FAIL reset_wready: got %b want 0", wready); end
        vectors++; if (arready !== 1'b0) begin miscompares++; $display("FAIL reset_arready: got %b want 0", arready); end
        vectors++; if (bvalid !== 1'b0) begin miscompares++; $display("FAIL reset_bvalid: got %b want 0", bvalid); end
        vectors++; if (rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
        vectors++; if (bresp !== 2'b00) begin miscompares++; $display("FAIL reset_bresp: got %b want 00", bresp); end
        vectors++; if (rresp !== 2'b00) begin miscompares++; $display("FAIL reset_rresp: got %b want 00", rresp); end
        vectors++; if (rdata !== 64'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
        rst = 0;
        #1;
        vectors++; if ({awready, wready, arready} !== 3'b111) begin miscompares++; $display("FAIL reset_release_readies: got %b want 111", {awready, wready, arready}); end
    endtask

    task automatic test_stall_pattern();
        bit exp;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp = !exp_stall();
            vectors++; if ({awready, wready, arready} !== {3{exp}}) begin miscompares++; $display("FAIL stall_readies cyc%0d: got %b want %b", since_rst, {awready, wready, arready}, {3{exp}}); end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] resp; logic [63:0] d; int lat; bit reopen, bst, baft, ok, rst_ok, raft;
        int bad_ok, bad_resp, bad_lat;
        bad_ok = 0; bad_resp = 0; bad_lat = 0;
        for (int i = 0; i < 2048; i++) begin
            axi_write(BASE + 64'(i % DEPTH), {32'hB2B0_0000, 32'(i)}, 0, 0, resp, lat, reopen, bst, baft, ok);
            if (!ok) bad_ok++;
            if (resp !== 2'b00) bad_resp++;
            if (lat !== 0 || reopen || baft) bad_lat++;
            ref_mem[i % DEPTH] = {32'hB2B0_0000, 32'(i)};
        end
        vectors++; if (bad_ok != 0) begin miscompares++; $display("FAIL b2b_complete: got %0d timeouts want 0", bad_ok); end
        vectors++; if (bad_resp != 0) begin miscompares++; $display("FAIL b2b_bresp: got %0d non-OKAY want 0", bad_resp); end
        vectors++; if (bad_lat != 0) begin miscompares++; $display("FAIL b2b_handshake: got %0d bad writes want 0", bad_lat); end
        for (int i = 0; i < DEPTH; i++) begin
            axi_read(BASE + 64'(i), 0, d, resp, lat, rst_ok, raft, ok);
            vectors++; if (!ok || d !== ref_mem[i] || resp !== 2'b00) begin miscompares++; $display("FAIL b2b_readback[%0d]: got %h/%b want %h/00", i, d, resp, ref_mem[i]); end
        end
    endtask

    task automatic test_same_cycle();
        logic [1:0] resp; logic [63:0] d; int lat; bit reopen, bst, baft, ok, rst_ok, raft;
        axi_write(64'h8000_0005, 64'hDEAD_BEEF, 0, 0, resp, lat, reopen, bst, baft, ok);
        ref_mem[5] = 64'hDEAD_BEEF;
        vectors++; if (!ok) begin miscompares++; $display("FAIL same_write_done: got %b want 1", ok); end
        vectors++; if (resp !== 2'b00) begin miscompares++; $display("FAIL same_bresp: got %b want 00", resp); end
        vectors++; if (lat !== 0) begin miscompares++; $display("FAIL same_bvalid_delay: got %0d want 0", lat); end
        vectors++; if (baft !== 1'b0) begin miscompares++; $display("FAIL same_bvalid_one_cycle: got %b want 0", baft); end
        axi_read(64'h8000_0005, 0, d, resp, lat, rst_ok, raft, ok);
        vectors++; if (!ok || d !== 64'hDEAD_BEEF) begin miscompares++; $display("FAIL same_rdata: got %h want deadbeef", d); end
        vectors++; if (resp !== 2'b00) begin miscompares++; $display("FAIL same_rresp: got %b want 00", resp); end
        vectors++; if (lat !== RL) begin miscompares++; $display("FAIL same_read_latency: got %0d want %0d", lat, RL); end
        vectors++; if (raft !== 1'b0) begin miscompares++; $display("FAIL same_rvalid_drop: got %b want 0", raft); end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] resp; logic [63:0] d; int lat; bit reopen, bst, baft, ok, rst_ok, raft;
        axi_write(BASE, 64'h11, 3, 0, resp, lat, reopen, bst, baft, ok);
        ref_mem[0] = 64'h11;
        vectors++; if (!ok || reopen) begin miscompares++; $display("FAIL wfirst_wready_held: ok %b reopen %b want 1 0", ok, reopen); end
        vectors++; if (lat !== 0 || resp !== 2'b00) begin miscompares++; $display("FAIL wfirst_b: delay %0d resp %b want 0 00", lat, resp); end
        axi_read(BASE, 0, d, resp, lat, rst_ok, raft, ok);
        vectors++; if (!ok || d !== 64'h11) begin miscompares++; $display("FAIL wfirst_readback: got %h want 11", d); end
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp; logic [63:0] d; int lat; bit reopen, bst, baft, ok, rst_ok, raft;
        logic [63:0] oor_rd [3];
        oor_rd[0] = 64'h7FFF_FFFF; oor_rd[1] = BASE + 64'(DEPTH); oor_rd[2] = 64'h1_8000_0005;
        axi_write(BASE + 64'(DEPTH), 64'hBAD0_BAD0, 0, 0, resp, lat, reopen, bst, baft, ok);
        vectors++; if (!ok || resp !== 2'b10) begin miscompares++; $display("FAIL oor_bresp: got %b want 10", resp); end
        axi_read(BASE, 0, d, resp, lat, rst_ok, raft, ok);
        vectors++; if (!ok || d !== ref_mem[0]) begin miscompares++; $display("FAIL oor_no_alias: got %h want %h", d, ref_mem[0]); end
        for (int i = 0; i < 3; i++) begin
            axi_read(oor_rd[i], 0, d, resp, lat, rst_ok, raft, ok);
            vectors++; if (!ok || resp !== 2'b10 || d !== 64'h0) begin miscompares++; $display("FAIL oor_read %h: got %h/%b want 0/10", oor_rd[i], d, resp); end
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] resp; logic [63:0] d; int lat; bit reopen, bst, baft, ok, rst_ok, raft;
        axi_write(BASE + 64'd7, 64'h0707_7070_A5A5_5A5A, -2, 5, resp, lat, reopen, bst, baft, ok);
        ref_mem[7] = 64'h0707_7070_A5A5_5A5A;
        vectors++; if (!ok || !bst) begin miscompares++; $display("FAIL bp_b_hold: ok %b stable %b want 1 1", ok, bst); end
        axi_read(BASE + 64'd7, 4, d, resp, lat, rst_ok, raft, ok);
        vectors++; if (!ok || !rst_ok) begin miscompares++; $display("FAIL bp_r_hold: ok %b stable %b want 1 1", ok, rst_ok); end
        vectors++; if (d !== ref_mem[7]) begin miscompares++; $display("FAIL bp_rdata: got %h want %h", d, ref_mem[7]); end
    endtask

    task automatic test_collision();
        logic [63:0] oldv, newv, d; logic [1:0] resp; int lat, cyc; bit rst_ok, raft, ok;
        oldv = ref_mem[9];
        newv = {$urandom, $urandom};
        cyc = 0;
        while (!(awready && wready && arready) && cyc < 10) begin
            tick();
            cyc++;
        end
        awaddr = BASE + 64'd9; araddr = BASE + 64'd9; wdata = newv;
        awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 0;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        vectors++; if (bvalid !== 1'b1) begin miscompares++; $display("FAIL coll_bvalid: got %b want 1", bvalid); end
        cyc = 0;
        while (!rvalid && cyc < 10) begin
            tick();
            cyc++;
        end
        bready = 0;
        vectors++; if (rvalid !== 1'b1 || rdata !== oldv) begin miscompares++; $display("FAIL coll_old_value: got %h want %h", rdata, oldv); end
        rready = 1;
        tick();
        rready = 0;
        ref_mem[9] = newv;
        axi_read(BASE + 64'd9, 0, d, resp, lat, rst_ok, raft, ok);
        vectors++; if (!ok || d !== newv) begin miscompares++; $display("FAIL coll_new_value: got %h want %h", d, newv); end
    endtask

    task automatic test_random();
        logic [1:0] resp, exp_resp; logic [63:0] addr, data, d, exp_d;
        int lat; bit reopen, bst, baft, ok, rst_ok, raft;
        for (int n = 0; n < 300; n++) begin
            addr = rand_addr();
            exp_resp = in_range(addr) ? 2'b00 : 2'b10;
            if ($urandom_range(0, 1) == 0) begin
                data = {$urandom, $urandom};
                axi_write(addr, data, $urandom_range(0, 6) - 3, $urandom_range(0, 2), resp, lat, reopen, bst, baft, ok);
                if (in_range(addr)) ref_mem[idx_of(addr)] = data;
                vectors++; if (!ok || resp !== exp_resp) begin miscompares++; $display("FAIL rnd_write %h: got %b want %b", addr, resp, exp_resp); end
                vectors++; if (lat !== 0 || reopen || !bst || baft) begin miscompares++; $display("FAIL rnd_write_hs %h: delay %0d reopen %b stable %b after %b", addr, lat, reopen, bst, baft); end
            end else begin
                exp_d = in_range(addr) ? ref_mem[idx_of(addr)] : 64'h0;
                axi_read(addr, $urandom_range(0, 2), d, resp, lat, rst_ok, raft, ok);
                vectors++; if (!ok || resp !== exp_resp || d !== exp_d) begin miscompares++; $display("FAIL rnd_read %h: got %h/%b want %h/%b", addr, d, resp, exp_d, exp_resp); end
                vectors++; if (lat !== RL || !rst_ok || raft) begin miscompares++; $display("FAIL rnd_read_hs %h: latency %0d stable %b after %b", addr, lat, rst_ok, raft); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] newv, d; logic [1:0] resp; int lat, cyc; bit rst_ok, raft, ok;
        newv = {$urandom, $urandom};
        awaddr = BASE + 64'd20; wdata = newv; awvalid = 1; wvalid = 1; bready = 0;
        cyc = 0;
        while (!(awready && wready) && cyc < 10) begin
            tick();
            cyc++;
        end
        tick();
        awvalid = 0; wvalid = 0;
        ref_mem[20] = newv;
        vectors++; if (bvalid !== 1'b1) begin miscompares++; $display("FAIL rmid_in_wresp: got %b want 1", bvalid); end
        araddr = BASE + 64'd21; arvalid = 1;
        cyc = 0;
        while (!arready && cyc < 10) begin
            tick();
            cyc++;
        end
        tick();
        arvalid = 0;
        vectors++; if (rvalid !== 1'b0 || bvalid !== 1'b1) begin miscompares++; $display("FAIL rmid_in_rwait: rvalid %b bvalid %b want 0 1", rvalid, bvalid); end
        rst = 1;
        tick();
        vectors++; if ({rvalid, bvalid} !== 2'b00) begin miscompares++; $display("FAIL rmid_flush: got %b want 00", {rvalid, bvalid}); end
        vectors++; if ({awready, wready, arready} !== 3'b000) begin miscompares++; $display("FAIL rmid_readies_in_rst: got %b want 000", {awready, wready, arready}); end
        rst = 0;
        #1;
        vectors++; if ({awready, wready, arready} !== 3'b111) begin miscompares++; $display("FAIL rmid_readies_after: got %b want 111", {awready, wready, arready}); end
        axi_read(BASE + 64'd20, 0, d, resp, lat, rst_ok, raft, ok);
        vectors++; if (!ok || d !== newv) begin miscompares++; $display("FAIL rmid_mem_kept: got %h want %h", d, newv); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stall_pattern();
        test_back_to_back();
        test_same_cycle();
        test_w_before_aw();
        test_out_of_range();
        test_backpressure();
        test_collision();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
